// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared definitions for the AES decryption datapath.
//   STATE_W / COL_W / NUM_COLS : state geometry (column 0 occupies the MSBs)
//   state_e                    : sequencer FSM encoding
//   col_lsb()                  : column index -> LSB of that column's bit range
package aes_dec_pkg;
   localparam int STATE_W  = 128;
   localparam int COL_W    = 32;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Column idx spans [col_lsb(idx) +: COL_W]; column 0 = [127:96], column 3 = [31:0].
   function automatic logic [6:0] col_lsb(input logic [1:0] idx);
      return {2'd3 - idx, 5'd0};
   endfunction
endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Block handshake bundle for inv_mix_columns_seq.
//   in_valid/in_ready/in_state/in_bypass : upstream block transfer
//   out_valid/out_ready/out_state        : downstream block transfer
//   busy                                 : sequencer is in RUN or DONE
// slave = the sequencer, master = the surrounding logic / bench.
interface inv_mix_columns_seq_if;
   import aes_dec_pkg::*;
   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] in_state;
   logic               in_bypass;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] out_state;
   logic               busy;

   modport slave (
      input  in_valid, in_state, in_bypass, out_ready,
      output in_ready, out_valid, out_state, busy
   );
   modport master (
      output in_valid, in_state, in_bypass, out_ready,
      input  in_ready, out_valid, out_state, busy
   );
endinterface

// File: rtl/inv_mix_columns_seq_helper.sv
// MixColumnHelper: combinational InvMixColumns on a single 32-bit column.
//   rc  : input column, byte 0 in [31:24]
//   mcl : mixed column, same byte order
module MixColumnHelper (
   input  logic [31:0] rc,
   output logic [31:0] mcl
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // 9, 11, 13, 14 built from repeated doubling (x2, x4, x8).
   function automatic logic [7:0] m9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction
   function automatic logic [7:0] m11(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction
   function automatic logic [7:0] m13(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction
   function automatic logic [7:0] m14(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   logic [7:0] a0, a1, a2, a3;
   assign {a0, a1, a2, a3} = rc;

   assign mcl = {m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3),
                 m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3),
                 m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3),
                 m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3)};
endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial InvMixColumns sequencer.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : block handshake (see inv_mix_columns_seq_if)
// A block is latched at the input handshake, its four columns are pushed one
// per cycle through a single shared MixColumnHelper, and the reassembled
// state is held in DONE until downstream accepts it. With BYPASS_EN set, an
// in_bypass block (final decryption round) skips RUN and goes straight to DONE.
module inv_mix_columns_seq
   import aes_dec_pkg::*;
#(
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   inv_mix_columns_seq_if.slave bus
);
   state_e             state_q;
   logic [1:0]         cnt_q;
   logic [STATE_W-1:0] src_q;
   logic [STATE_W-1:0] result_q;
   logic [COL_W-1:0]   col_in;
   logic [COL_W-1:0]   col_out;

   always_comb col_in = src_q[col_lsb(cnt_q) +: COL_W];

   MixColumnHelper u_helper (
      .rc  (col_in),
      .mcl (col_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         src_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  src_q <= bus.in_state;
                  cnt_q <= 2'd0;
                  if (BYPASS_EN && bus.in_bypass) begin
                     result_q <= bus.in_state;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= RUN;
                  end
               end
            end
            RUN: begin
               result_q[col_lsb(cnt_q) +: COL_W] <= col_out;
               // Saturate at the last column so cnt never wraps inside a block.
               if (cnt_q == 2'd3) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // All outputs decode straight from registers; no input-to-output paths.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_state = result_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq. Two instances: u_a honours
// in_bypass, u_b ignores it. Expected results come from a byte-matrix
// GF(2^8) reference model and from known-answer constants.
module tb_inv_mix_columns_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   inv_mix_columns_seq_if a_if ();
   inv_mix_columns_seq_if b_if ();

   inv_mix_columns_seq #(.BYPASS_EN(1'b1)) u_a (.clk(clk), .rst(rst), .bus(a_if));
   inv_mix_columns_seq #(.BYPASS_EN(1'b0)) u_b (.clk(clk), .rst(rst), .bus(b_if));

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
      int unsigned m [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13},
                                '{13, 9, 14, 11}, '{11, 13, 9, 14}};
      logic [7:0]   bi [16];
      logic [7:0]   acc;
      logic [127:0] r = '0;
      for (int k = 0; k < 16; k++) bi[k] = s[127 - 8*k -: 8];
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(bi[4*c + j], 8'(m[row][j]));
            r[127 - 8*(4*c + row) -: 8] = acc;
         end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int sel, input logic v, input logic [127:0] st, input logic byp);
      if (sel == 0) begin
         a_if.in_valid = v; a_if.in_state = st; a_if.in_bypass = byp;
      end else begin
         b_if.in_valid = v; b_if.in_state = st; b_if.in_bypass = byp;
      end
   endtask

   function automatic logic ov(input int sel);
      return (sel == 0) ? a_if.out_valid : b_if.out_valid;
   endfunction
   function automatic logic ir(input int sel);
      return (sel == 0) ? a_if.in_ready : b_if.in_ready;
   endfunction
   function automatic logic bz(input int sel);
      return (sel == 0) ? a_if.busy : b_if.busy;
   endfunction
   function automatic logic [127:0] os(input int sel);
      return (sel == 0) ? a_if.out_state : b_if.out_state;
   endfunction

   // One block end to end with out_ready high. lat = further edges after the
   // accepting edge before out_valid is seen (mixed: 4, i.e. the 5th edge
   // counting the accept; bypass: 0). Inputs are scrambled right after accept.
   task automatic run_block(input string tag, input int sel, input logic [127:0] st,
                            input logic byp, input int lat, input logic [127:0] exp);
      int n = 0;
      drv(sel, 1'b1, st, byp);
      chk({tag, ".in_ready"}, 128'(ir(sel)), 128'd1);
      step();
      drv(sel, 1'b0, ~st, ~byp);
      while (!ov(sel) && n < 20) begin
         step();
         n++;
      end
      chk({tag, ".latency"}, 128'(n), 128'(lat));
      chk({tag, ".out_state"}, os(sel), exp);
      chk({tag, ".busy_done"}, {126'd0, bz(sel), ir(sel)}, {126'd0, 1'b1, 1'b0});
      step();
      chk({tag, ".after_xfer"}, {125'd0, ov(sel), ir(sel), bz(sel)}, {125'd0, 1'b0, 1'b1, 1'b0});
   endtask

   localparam logic [127:0] KA_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] KA_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
   localparam logic [127:0] C6     = {4{32'hc6c6c6c6}};

   initial begin
      logic [127:0] st, held;
      logic [127:0] bq [3];
      logic [127:0] outs [$];
      int           acc_cyc [$];
      int           ai, cyc, n;
      logic         acc;

      a_if.out_ready = 1'b1;
      b_if.out_ready = 1'b1;
      drv(0, 1'b0, '0, 1'b0);
      drv(1, 1'b0, '0, 1'b0);

      // Reset
      step(); step();
      rst = 1'b0;
      chk("reset.a", {a_if.out_state, 3'(0)} , {128'd0, 3'(0)});
      chk("reset.a_flags", {125'd0, a_if.out_valid, a_if.in_ready, a_if.busy}, {125'd0, 1'b0, 1'b1, 1'b0});
      chk("reset.b_flags", {125'd0, b_if.out_valid, b_if.in_ready, b_if.busy}, {125'd0, 1'b0, 1'b1, 1'b0});

      // Known-answer single block, bypass, and bypass ignored
      run_block("ka_mix", 0, KA_IN, 1'b0, 4, KA_OUT);
      run_block("ka_byp", 0, KA_IN, 1'b1, 0, KA_IN);
      run_block("ka_noen", 1, KA_IN, 1'b1, 4, KA_OUT);

      // Random blocks against the model
      for (int i = 0; i < 4; i++) begin
         st = rnd128();
         run_block("rnd_mix", 0, st, 1'b0, 4, ref_inv_mix(st));
      end
      st = rnd128();
      run_block("rnd_byp", 0, st, 1'b1, 0, st);
      st = rnd128();
      run_block("rnd_noen", 1, st, 1'b1, 4, ref_inv_mix(st));

      // Backpressure: hold DONE for 10 cycles, second in_valid must be ignored
      a_if.out_ready = 1'b0;
      drv(0, 1'b1, C6, 1'b0);
      step();
      drv(0, 1'b0, '0, 1'b0);
      n = 0;
      while (!a_if.out_valid && n < 20) begin
         step();
         n++;
      end
      chk("bp.latency", 128'(n), 128'd4);
      held = a_if.out_state;
      chk("bp.value", held, C6);
      for (int i = 0; i < 10; i++) begin
         drv(0, 1'b1, rnd128(), 1'b0);
         step();
         chk("bp.hold_valid", {126'd0, a_if.out_valid, a_if.in_ready}, {126'd0, 1'b1, 1'b0});
         chk("bp.hold_state", a_if.out_state, C6);
      end
      drv(0, 1'b0, '0, 1'b0);
      a_if.out_ready = 1'b1;
      step();
      chk("bp.release", {125'd0, a_if.out_valid, a_if.in_ready, a_if.busy}, {125'd0, 1'b0, 1'b1, 1'b0});
      step();
      chk("bp.no_second", {126'd0, a_if.out_valid, a_if.busy}, 128'd0);

      // Back-to-back: in_valid held high, accepts every 6 cycles
      bq[0] = rnd128();
      bq[1] = {$urandom, $urandom, 32'h4d7ebdf8, $urandom};
      bq[2] = rnd128();
      ai = 0; cyc = 0;
      drv(0, 1'b1, bq[0], 1'b0);
      while ((ai < 3 || outs.size() < 3) && cyc < 100) begin
         acc = a_if.in_valid && a_if.in_ready;
         if (a_if.out_valid && a_if.out_ready) outs.push_back(a_if.out_state);
         step();
         cyc++;
         if (acc) begin
            acc_cyc.push_back(cyc);
            ai++;
            if (ai < 3) drv(0, 1'b1, bq[ai], 1'b0);
            else        drv(0, 1'b0, '0, 1'b0);
         end
      end
      chk("b2b.timeout", 128'(cyc < 100), 128'd1);
      chk("b2b.n_out", 128'(outs.size()), 128'd3);
      chk("b2b.n_acc", 128'(acc_cyc.size()), 128'd3);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("b2b.spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd6);
      for (int i = 0; i < outs.size() && i < 3; i++)
         chk("b2b.data", outs[i], ref_inv_mix(bq[i]));
      if (outs.size() > 1) chk("b2b.col2", 128'(outs[1][63:32]), 128'h2d26314c);
      step();

      // Reset while cnt == 2
      drv(0, 1'b1, rnd128(), 1'b0);
      step();
      drv(0, 1'b0, '0, 1'b0);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_run.flags", {125'd0, a_if.out_valid, a_if.in_ready, a_if.busy}, {125'd0, 1'b0, 1'b1, 1'b0});
      chk("rst_run.state", a_if.out_state, 128'd0);
      step(); step(); step(); step();
      chk("rst_run.no_emit", {126'd0, a_if.out_valid, a_if.busy}, 128'd0);
      st = rnd128();
      run_block("rst_run.fresh", 0, st, 1'b0, 4, ref_inv_mix(st));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
